// File: rtl/status_flag_unit.sv
// Architectural Z/C/N/V status register with a forwarded next value
// and a one-entry shadow copy for exception save/restore.
module status_flag_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exe_valid,
  input  logic                  s_bit,
  input  logic [3:0]            exe_cmd,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  save,
  input  logic                  restore,
  output logic [3:0]            status_out,
  output logic [3:0]            status_fwd,
  output logic [3:0]            shadow_out,
  output logic                  flags_updated
);

  logic       is_arith;
  logic       is_logic;
  logic       zn;
  logic       nn;
  logic       upd;
  logic [3:0] new_flags;

  always_comb begin
    is_arith = 1'b0;
    is_logic = 1'b0;
    unique case (exe_cmd)
      4'b0010, 4'b0011, 4'b0100, 4'b0101:          is_arith = 1'b1;
      4'b0001, 4'b1001, 4'b0110, 4'b0111, 4'b1000: is_logic = 1'b1;
      default: ;
    endcase
  end

  assign zn  = (alu_result == '0);
  assign nn  = alu_result[DATA_WIDTH-1];
  assign upd = exe_valid & s_bit & ~flush & ~freeze & (is_arith | is_logic);

  // Logical ops keep C/V from the current register, so back-to-back writers never see stale values.
  always_comb begin
    if (is_arith) new_flags = {zn, alu_carry, nn, alu_overflow};
    else          new_flags = {zn, status_out[2], nn, status_out[0]};
  end

  always_comb begin
    status_fwd = status_out;
    if (!rst && !freeze) begin
      if (restore)  status_fwd = shadow_out;
      else if (upd) status_fwd = new_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_out    <= RESET_FLAGS;
      shadow_out    <= RESET_FLAGS;
      flags_updated <= 1'b0;
    end else begin
      status_out    <= status_fwd;
      flags_updated <= upd & ~restore;
      if (save && !freeze) shadow_out <= status_out;
    end
  end

endmodule
